// File: rtl/demux_stream_if.sv
// demux_stream_if: stream bundle for the demux_stream block.
//   Input side : in_valid, in_ready, in_data, in_sel (one producer).
//   Output side: out_valid, out_ready, out_data (N_OUT consumers, packed,
//                output i on out_data[i*WIDTH +: WIDTH]).
//   master : producer/consumer environment driving the block.
//   slave  : the demultiplexer itself.
interface demux_stream_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned N_OUT = 4,
   parameter int unsigned SEL_W = $clog2(N_OUT)
);
   logic                   in_valid;
   logic                   in_ready;
   logic [WIDTH-1:0]       in_data;
   logic [SEL_W-1:0]       in_sel;
   logic [N_OUT-1:0]       out_valid;
   logic [N_OUT-1:0]       out_ready;
   logic [N_OUT*WIDTH-1:0] out_data;

   modport master (
      output in_valid, in_data, in_sel, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, in_sel, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/demux_stream.sv
// demux_stream: routes each input beat to one of N_OUT output streams chosen
// by in_sel. Each output owns a 2-entry FIFO so a stalled consumer does not
// block beats to other outputs. Beats with in_sel >= N_OUT are accepted,
// discarded and counted in a saturating 8-bit drop counter.
// Ports:
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset
//   bus      : demux_stream_if.slave (input stream + N_OUT output streams)
//   drop_cnt : saturating count of dropped (out-of-range) beats
module demux_stream #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned N_OUT = 4,
   parameter int unsigned SEL_W = $clog2(N_OUT)
) (
   input  logic          clk,
   input  logic          rst_n,
   demux_stream_if.slave bus,
   output logic [7:0]    drop_cnt
);

   logic [WIDTH-1:0] mem_q [N_OUT][2];
   logic [WIDTH-1:0] mem_d [N_OUT][2];
   logic [1:0]       cnt_q [N_OUT];
   logic [1:0]       cnt_d [N_OUT];
   logic [N_OUT-1:0] rd_ptr_q, rd_ptr_d;
   logic [N_OUT-1:0] wr_ptr_q, wr_ptr_d;
   logic [7:0]       drop_cnt_q, drop_cnt_d;

   logic [N_OUT-1:0] push;
   logic [N_OUT-1:0] pop;
   logic [N_OUT-1:0] vld;
   logic             in_range;
   logic             sel_full;
   logic             in_rdy;
   int unsigned      sel_idx;

   // Acceptance looks only at registered counts, so out_ready never reaches in_ready.
   always_comb begin
      sel_idx  = 32'(bus.in_sel);
      in_range = (sel_idx < N_OUT);
      sel_full = 1'b0;
      for (int unsigned i = 0; i < N_OUT; i++) begin
         if ((sel_idx == i) && (cnt_q[i] == 2'd2)) begin
            sel_full = 1'b1;
         end
      end
      in_rdy = in_range ? ~sel_full : 1'b1;
   end

   assign bus.in_ready = in_rdy;

   always_comb begin
      push         = '0;
      pop          = '0;
      vld          = '0;
      bus.out_data = '0;
      for (int unsigned i = 0; i < N_OUT; i++) begin
         vld[i]                         = (cnt_q[i] != 2'd0);
         bus.out_data[i*WIDTH +: WIDTH] = mem_q[i][rd_ptr_q[i]];
         pop[i]                         = vld[i] & bus.out_ready[i];
         push[i]                        = bus.in_valid & in_rdy & (sel_idx == i);
      end
   end

   assign bus.out_valid = vld;

   always_comb begin
      mem_d      = mem_q;
      cnt_d      = cnt_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      drop_cnt_d = drop_cnt_q;
      for (int unsigned i = 0; i < N_OUT; i++) begin
         if (push[i]) begin
            mem_d[i][wr_ptr_q[i]] = bus.in_data;
            wr_ptr_d[i]           = ~wr_ptr_q[i];
         end
         if (pop[i]) begin
            rd_ptr_d[i] = ~rd_ptr_q[i];
         end
         // Simultaneous push and pop leaves the count unchanged.
         if (push[i] && !pop[i]) begin
            cnt_d[i] = cnt_q[i] + 2'd1;
         end else if (!push[i] && pop[i]) begin
            cnt_d[i] = cnt_q[i] - 2'd1;
         end
      end
      // Out-of-range beats are always ready, so valid alone means a transfer.
      if (bus.in_valid && !in_range && (drop_cnt_q != 8'hFF)) begin
         drop_cnt_d = drop_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < N_OUT; i++) begin
            mem_q[i][0] <= '0;
            mem_q[i][1] <= '0;
            cnt_q[i]    <= '0;
         end
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         drop_cnt_q <= '0;
      end else begin
         mem_q      <= mem_d;
         cnt_q      <= cnt_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_demux_stream.sv
// tb_demux_stream: self-checking bench for demux_stream. Two instances:
//   u_dut4 : N_OUT=4 (every select in range) for routing/backpressure tests
//   u_dut3 : N_OUT=3, SEL_W=2 (select 3 is out of range) for drop tests
// A queue-per-output reference model tracks expected contents and drops.
module tb_demux_stream;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   demux_stream_if #(.WIDTH(8), .N_OUT(4), .SEL_W(2)) bus4 ();
   demux_stream_if #(.WIDTH(8), .N_OUT(3), .SEL_W(2)) bus3 ();
   logic [7:0] drop4;
   logic [7:0] drop3;

   demux_stream #(.WIDTH(8), .N_OUT(4), .SEL_W(2)) u_dut4 (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus4.slave),
      .drop_cnt (drop4)
   );

   demux_stream #(.WIDTH(8), .N_OUT(3), .SEL_W(2)) u_dut3 (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus3.slave),
      .drop_cnt (drop3)
   );

   typedef logic [7:0] byte_q_t [$];
   byte_q_t q4 [4];
   byte_q_t q3 [3];
   int mdrop3 = 0;
   int checks = 0;
   int errors = 0;

   task automatic idle();
      bus4.in_valid = 1'b0;
      bus4.in_sel   = '0;
      bus4.in_data  = '0;
      bus3.in_valid = 1'b0;
      bus3.in_sel   = '0;
      bus3.in_data  = '0;
   endtask

   task automatic clear_model();
      for (int i = 0; i < 4; i++) q4[i].delete();
      for (int i = 0; i < 3; i++) q3[i].delete();
      mdrop3 = 0;
   endtask

   function automatic logic exp_ready4();
      int s;
      s = int'(bus4.in_sel);
      if (s >= 4) return 1'b1;
      return (q4[s].size() < 2);
   endfunction

   function automatic logic exp_ready3();
      int s;
      s = int'(bus3.in_sel);
      if (s >= 3) return 1'b1;
      return (q3[s].size() < 2);
   endfunction

   // Advance one clock and apply the transfers the model predicts for it.
   task automatic step();
      bit         pop4 [4];
      bit         push4 [4];
      bit         pop3 [3];
      bit         push3 [3];
      bit         drop;
      int         s4, s3;
      logic [7:0] d4, d3;
      s4 = int'(bus4.in_sel);
      s3 = int'(bus3.in_sel);
      d4 = bus4.in_data;
      d3 = bus3.in_data;
      for (int i = 0; i < 4; i++) begin
         pop4[i]  = (q4[i].size() != 0) && bus4.out_ready[i];
         push4[i] = bus4.in_valid && (s4 == i) && (q4[i].size() < 2);
      end
      for (int i = 0; i < 3; i++) begin
         pop3[i]  = (q3[i].size() != 0) && bus3.out_ready[i];
         push3[i] = bus3.in_valid && (s3 == i) && (q3[i].size() < 2);
      end
      drop = bus3.in_valid && (s3 >= 3);
      @(posedge clk);
      for (int i = 0; i < 4; i++) begin
         if (pop4[i]) void'(q4[i].pop_front());
         if (push4[i]) q4[i].push_back(d4);
      end
      for (int i = 0; i < 3; i++) begin
         if (pop3[i]) void'(q3[i].pop_front());
         if (push3[i]) q3[i].push_back(d3);
      end
      if (drop && (mdrop3 < 255)) mdrop3++;
      #1;
   endtask

   task automatic test_reset();
      idle();
      bus4.out_ready = '0;
      bus3.out_ready = '0;
      repeat (2) @(negedge clk);
      checks++;
      if (bus4.out_valid !== 4'b0000) begin
         errors++;
         $display("FAIL reset_hold_valid got %b want 0000", bus4.out_valid);
      end
      @(negedge clk);
      rst_n = 1'b1;
      bus4.in_valid = 1'b1;
      bus4.in_sel   = 2'd0;
      bus4.in_data  = 8'h5C;
      step();
      bus4.in_sel  = 2'd2;
      bus4.in_data = 8'h7E;
      step();
      idle();
      #1;
      checks++;
      if (bus4.out_valid !== 4'b0101) begin
         errors++;
         $display("FAIL reset_prefill got %b want 0101", bus4.out_valid);
      end
      rst_n = 1'b0;
      clear_model();
      bus4.in_sel = 2'd2;
      #1;
      checks++;
      if (bus4.out_valid !== 4'b0000) begin
         errors++;
         $display("FAIL reset_valid got %b want 0000", bus4.out_valid);
      end
      checks++;
      if (bus4.out_data !== 32'h0) begin
         errors++;
         $display("FAIL reset_data got %h want 0", bus4.out_data);
      end
      checks++;
      if (drop4 !== 8'd0 || drop3 !== 8'd0) begin
         errors++;
         $display("FAIL reset_drop got %0d/%0d want 0/0", drop4, drop3);
      end
      checks++;
      if (bus4.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready got %b want 1", bus4.in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      idle();
   endtask

   task automatic test_routing();
      logic [7:0] vals [4];
      vals[0] = 8'h11;
      vals[1] = 8'h22;
      vals[2] = 8'h33;
      vals[3] = 8'h44;
      bus4.out_ready = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         bus4.in_valid = 1'b1;
         bus4.in_sel   = 2'(k);
         bus4.in_data  = vals[k];
         #1;
         checks++;
         if (bus4.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL route_ready[%0d] got %b want 1", k, bus4.in_ready);
         end
         step();
         checks++;
         if (bus4.out_valid[k] !== 1'b1 || bus4.out_data[k*8 +: 8] !== vals[k]) begin
            errors++;
            $display("FAIL route_out[%0d] got v=%b d=%h want v=1 d=%h", k, bus4.out_valid[k],
                     bus4.out_data[k*8 +: 8], vals[k]);
         end
      end
      idle();
      step();
      checks++;
      if (bus4.out_valid !== 4'b0000) begin
         errors++;
         $display("FAIL route_drain got %b want 0000", bus4.out_valid);
      end
   endtask

   task automatic test_backpressure();
      bus4.out_ready = 4'b1101;
      bus4.in_valid  = 1'b1;
      bus4.in_sel    = 2'd1;
      bus4.in_data   = 8'hA0;
      #1;
      checks++;
      if (bus4.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_ready_a0 got %b want 1", bus4.in_ready);
      end
      step();
      bus4.in_data = 8'hA1;
      #1;
      checks++;
      if (bus4.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_ready_a1 got %b want 1", bus4.in_ready);
      end
      step();
      bus4.in_data = 8'hA2;
      #1;
      checks++;
      if (bus4.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_ready_a2 got %b want 0", bus4.in_ready);
      end
      step();
      checks++;
      if (bus4.out_valid[1] !== 1'b1 || bus4.out_data[15:8] !== 8'hA0) begin
         errors++;
         $display("FAIL bp_hold got v=%b d=%h want v=1 d=a0", bus4.out_valid[1],
                  bus4.out_data[15:8]);
      end
      bus4.in_sel  = 2'd3;
      bus4.in_data = 8'hB0;
      #1;
      checks++;
      if (bus4.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_ready_b0 got %b want 1", bus4.in_ready);
      end
      step();
      checks++;
      if (bus4.out_valid[3] !== 1'b1 || bus4.out_data[31:24] !== 8'hB0) begin
         errors++;
         $display("FAIL bp_out3 got v=%b d=%h want v=1 d=b0", bus4.out_valid[3],
                  bus4.out_data[31:24]);
      end
      bus4.in_sel    = 2'd1;
      bus4.in_data   = 8'hA2;
      bus4.out_ready = 4'b1111;
      #1;
      checks++;
      if (bus4.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_no_passthru got %b want 0", bus4.in_ready);
      end
      step();
      checks++;
      if (bus4.out_data[15:8] !== 8'hA1 || bus4.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_pop_a0 got d=%h rdy=%b want d=a1 rdy=1", bus4.out_data[15:8],
                  bus4.in_ready);
      end
      step();
      checks++;
      if (bus4.out_valid[1] !== 1'b1 || bus4.out_data[15:8] !== 8'hA2) begin
         errors++;
         $display("FAIL bp_pop_a1 got v=%b d=%h want v=1 d=a2", bus4.out_valid[1],
                  bus4.out_data[15:8]);
      end
      idle();
      step();
      checks++;
      if (bus4.out_valid !== 4'b0000) begin
         errors++;
         $display("FAIL bp_drain got %b want 0000", bus4.out_valid);
      end
   endtask

   task automatic test_push_pop();
      bus4.out_ready = 4'b1111;
      for (int k = 1; k <= 8; k++) begin
         bus4.in_valid = 1'b1;
         bus4.in_sel   = 2'd2;
         bus4.in_data  = 8'(k);
         #1;
         checks++;
         if (bus4.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL pp_ready[%0d] got %b want 1", k, bus4.in_ready);
         end
         step();
         checks++;
         if (bus4.out_valid !== 4'b0100 || bus4.out_data[23:16] !== 8'(k)) begin
            errors++;
            $display("FAIL pp_out[%0d] got v=%b d=%h want v=0100 d=%h", k, bus4.out_valid,
                     bus4.out_data[23:16], 8'(k));
         end
      end
      idle();
      step();
      checks++;
      if (bus4.out_valid !== 4'b0000) begin
         errors++;
         $display("FAIL pp_drain got %b want 0000", bus4.out_valid);
      end
   endtask

   task automatic test_drop();
      bus3.out_ready = 3'b111;
      for (int k = 0; k < 300; k++) begin
         bus3.in_valid = 1'b1;
         bus3.in_sel   = 2'd3;
         bus3.in_data  = 8'($urandom);
         #1;
         checks++;
         if (bus3.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL drop_ready[%0d] got %b want 1", k, bus3.in_ready);
         end
         step();
         checks++;
         if (bus3.out_valid !== 3'b000 || int'(drop3) !== mdrop3) begin
            errors++;
            $display("FAIL drop_cnt[%0d] got v=%b cnt=%0d want v=000 cnt=%0d", k,
                     bus3.out_valid, drop3, mdrop3);
         end
      end
      idle();
      checks++;
      if (drop3 !== 8'd255) begin
         errors++;
         $display("FAIL drop_saturate got %0d want 255", drop3);
      end
   endtask

   task automatic test_reset_mid();
      bus4.out_ready = 4'b0000;
      for (int k = 0; k < 4; k++) begin
         bus4.in_valid = 1'b1;
         bus4.in_sel   = 2'(k / 2);
         bus4.in_data  = 8'(8'hC0 + k);
         step();
      end
      idle();
      #1;
      checks++;
      if (bus4.out_valid !== 4'b0011 || bus4.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL rmid_full got v=%b rdy=%b want v=0011 rdy=0", bus4.out_valid,
                  bus4.in_ready);
      end
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      clear_model();
      #1;
      checks++;
      if (bus4.out_valid !== 4'b0000 || bus4.out_data !== 32'h0 || drop3 !== 8'd0) begin
         errors++;
         $display("FAIL rmid_async got v=%b d=%h drop=%0d want 0000/0/0", bus4.out_valid,
                  bus4.out_data, drop3);
      end
      @(negedge clk);
      rst_n = 1'b1;
      bus4.out_ready = 4'b1111;
      bus4.in_valid  = 1'b1;
      bus4.in_sel    = 2'd1;
      bus4.in_data   = 8'h5A;
      step();
      idle();
      checks++;
      if (bus4.out_valid !== 4'b0010 || bus4.out_data[15:8] !== 8'h5A) begin
         errors++;
         $display("FAIL rmid_after got v=%b d=%h want v=0010 d=5a", bus4.out_valid,
                  bus4.out_data[15:8]);
      end
      step();
   endtask

   task automatic test_random();
      for (int c = 0; c < 500; c++) begin
         bus4.in_valid  = 1'($urandom_range(0, 1));
         bus4.in_sel    = 2'($urandom_range(0, 3));
         bus4.in_data   = 8'($urandom);
         bus4.out_ready = 4'($urandom);
         bus3.in_valid  = 1'($urandom_range(0, 1));
         bus3.in_sel    = 2'($urandom_range(0, 3));
         bus3.in_data   = 8'($urandom);
         bus3.out_ready = 3'($urandom);
         #1;
         checks++;
         if (bus4.in_ready !== exp_ready4() || bus3.in_ready !== exp_ready3()) begin
            errors++;
            $display("FAIL rnd_ready[%0d] got %b/%b want %b/%b", c, bus4.in_ready,
                     bus3.in_ready, exp_ready4(), exp_ready3());
         end
         step();
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus4.out_valid[i] !== (q4[i].size() != 0) ||
                (q4[i].size() != 0 && bus4.out_data[i*8 +: 8] !== q4[i][0])) begin
               errors++;
               $display("FAIL rnd_out4[%0d] cyc %0d got v=%b d=%h want v=%b", i, c,
                        bus4.out_valid[i], bus4.out_data[i*8 +: 8], q4[i].size() != 0);
            end
         end
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus3.out_valid[i] !== (q3[i].size() != 0) ||
                (q3[i].size() != 0 && bus3.out_data[i*8 +: 8] !== q3[i][0])) begin
               errors++;
               $display("FAIL rnd_out3[%0d] cyc %0d got v=%b d=%h want v=%b", i, c,
                        bus3.out_valid[i], bus3.out_data[i*8 +: 8], q3[i].size() != 0);
            end
         end
         checks++;
         if (int'(drop3) !== mdrop3 || drop4 !== 8'd0) begin
            errors++;
            $display("FAIL rnd_drop cyc %0d got %0d/%0d want %0d/0", c, drop3, drop4, mdrop3);
         end
      end
      idle();
   endtask

   initial begin
      idle();
      bus4.out_ready = '0;
      bus3.out_ready = '0;
      test_reset();
      test_routing();
      test_backpressure();
      test_push_pop();
      test_drop();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout after 500000 time units");
      $fatal(1, "watchdog");
   end

endmodule
